turn_timer: RTL and testbench
=============================

# turn_timer

Per-turn countdown timer for the tic-tac-toe game. It counts down a fixed number of seconds each time a player's turn starts and presents the remaining time as two BCD digits, each of which drives one 4-bit seven-segment decoder input. It sits between the game controller, which issues `start` and `move_done`, and the two seven-segment decoder instances. It flags a timeout back to the controller.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second; legal range ≥ 2. Benches override it to a small value.
- `TURN_SECS`, default 15: seconds loaded on each start; legal range 1..99.
- `WARN_SECS`, default 5: `warn` asserts while the count is ≤ this value; legal range 0..99.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: one-cycle pulse that loads `TURN_SECS` and begins counting.
- `move_done`, input, 1: one-cycle pulse that stops the count and holds the digits.
- `pause`, input, 1: level signal; while high, the count and prescaler freeze.
- `tens`, output, 4: BCD tens digit (0..9), fed to a decoder.
- `ones`, output, 4: BCD ones digit (0..9), fed to a decoder.
- `running`, output, 1: high while in state RUN.
- `warn`, output, 1: `running` AND count ≤ `WARN_SECS`.
- `timeout`, output, 1: one-cycle pulse when the count reaches 00.

## Operation
- Reset values:
  - state IDLE;
  - `tens` = 0, `ones` = 0;
  - prescaler = 0;
  - `running` = 0, `warn` = 0, `timeout` = 0.
- The state machine is {IDLE, RUN, EXPIRED}.
- `start` in any state:
  - `tens` = `TURN_SECS`/10, `ones` = `TURN_SECS`%10;
  - prescaler = 0;
  - next state RUN.
- In RUN with `pause` = 0:
  - the prescaler increments;
  - at `CLK_HZ`−1 it wraps to 0 and produces a one-cycle tick.
- On a tick, the count decrements in BCD:
  - if `ones` > 0, then `ones`−1;
  - otherwise `ones` = 9 and `tens`−1.
- On a tick with the count at 01:
  - digits become 00;
  - next state EXPIRED;
  - `timeout` = 1 for exactly that one cycle.
- `move_done` in RUN: next state IDLE; digits and prescaler hold. `move_done` in IDLE or EXPIRED is ignored.
- EXPIRED holds 00 until `start`. `timeout` never re-fires without a new `start`.
- In IDLE and EXPIRED the prescaler is held at 0.
- `pause` in RUN freezes both the prescaler and the digits. On release, counting resumes from the frozen prescaler value; the partial second is preserved.
- Simultaneous events:
  - `start` with `move_done` in the same cycle: `start` wins.
  - `start` coincident with a tick: the load wins and the tick is discarded.
  - `move_done` coincident with the final tick: `move_done` wins; next state IDLE, digits stay at 01, no `timeout`.
- Digits are always valid BCD (0..9). No code above 9 is ever presented to the decoders.
- Reset asserted mid-count forces all reset values immediately and asynchronously. No pulse is emitted on deassertion.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- The `start` pulse sampled at edge k gives new digits and `running` = 1 after edge k.
- The first decrement occurs at edge k+`CLK_HZ`; each subsequent decrement follows `CLK_HZ` cycles later (excluding paused cycles).
- Without pause, `timeout` asserts after edge k+`TURN_SECS`·`CLK_HZ`, coincident with digits 00, state EXPIRED, `running` = 0.
- `move_done` at edge m gives `running` = 0 after edge m.
- `warn` updates in the same cycle as the digits or state it depends on.

## Structure
- Shared package `ttt_pkg` holds:
  - `timer_state_t` enum {IDLE, RUN, EXPIRED};
  - `bcd_t` (logic [3:0]);
  - the BCD maximum constant 9.
- One sub-module, `tick_gen`: a prescaler with inputs `clk`, `rst_n`, `clear`, `enable` and a single-cycle `tick` output. Width is `$clog2(CLK_HZ)`.
- The top level holds the FSM, the BCD digit registers and the output flags.
- `tens` and `ones` connect directly to two decoder instances at the top of the design.

## Test plan
- Reset: hold `rst_n` = 0 mid-RUN → `tens`/`ones` = 0/0, `running` = 0, `timeout` = 0 immediately. After release, no activity until `start`.
- Full countdown (`CLK_HZ`=4, `TURN_SECS`=12, `WARN_SECS`=5):
  - pulse `start` → 1,2 next cycle;
  - digits step 1,1 → 1,0 → 0,9 (borrow) every 4 cycles;
  - `warn` rises at 0,5;
  - `timeout` is a single pulse at 0,0 after 48 cycles, then EXPIRED holds.
- `move_done` at 0,7 → `running` = 0, digits hold 0,7 indefinitely. A later `start` reloads 1,2.
- Pause at count 0,9 with the prescaler at 2, held 10 cycles → no change. After release, the next decrement comes 2 cycles later.
- `start` and `move_done` in the same cycle from RUN → reload to 1,2, `running` stays 1.
- `move_done` coincident with the final tick at 0,1 → IDLE, digits 0,1, no `timeout`.
- `start` in EXPIRED → reload, RUN, `timeout` stays 0.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn timer.
// The BCD helper lets comparisons be written on the seconds value rather than on digits.
package ttt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic int bcd_value(input bcd_t tens_digit, input bcd_t ones_digit);
        return int'(tens_digit) * 10 + int'(ones_digit);
    endfunction

endpackage

// File: rtl/turn_timer_if.sv
// Controller <-> turn timer connection: control pulses in, BCD digits and flags out.
interface turn_timer_if;
    import ttt_pkg::*;

    logic start;
    logic move_done;
    logic pause;
    bcd_t tens;
    bcd_t ones;
    logic running;
    logic warn;
    logic timeout;

    modport master (
        output start, move_done, pause,
        input  tens, ones, running, warn, timeout
    );

    modport slave (
        input  start, move_done, pause,
        output tens, ones, running, warn, timeout
    );

endinterface

// File: rtl/turn_timer_tick_gen.sv
// One-second prescaler: counts enabled cycles and flags the cycle on which it wraps.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = $clog2(CLK_HZ);
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // The tick coincides with the wrap edge so the digit update lands on the same edge.
    assign tick = enable && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            if (tick) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown timer: loads TURN_SECS on start, counts down once per second in BCD,
// and reports running / warn / timeout back to the game controller.
module turn_timer
    import ttt_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TURN_SECS = 15,
    parameter int WARN_SECS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    turn_timer_if.slave  bus
);

    localparam bcd_t LOAD_TENS = bcd_t'(TURN_SECS / 10);
    localparam bcd_t LOAD_ONES = bcd_t'(TURN_SECS % 10);

    timer_state_t state_reg;
    timer_state_t state_next;
    bcd_t         tens_reg;
    bcd_t         tens_next;
    bcd_t         ones_reg;
    bcd_t         ones_next;
    logic         running_reg;
    logic         running_next;
    logic         warn_reg;
    logic         warn_next;
    logic         timeout_reg;
    logic         timeout_next;

    logic         tick;
    logic         at_final;

    // Start and move_done both pre-empt the tick, so the prescaler must not advance under them.
    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.start || (state_reg != RUN)),
        .enable ((state_reg == RUN) && !bus.pause && !bus.start && !bus.move_done),
        .tick   (tick)
    );

    assign at_final = (tens_reg == 4'd0) && (ones_reg == 4'd1);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tens_reg    <= '0;
            ones_reg    <= '0;
            running_reg <= 1'b0;
            warn_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tens_reg    <= tens_next;
            ones_reg    <= ones_next;
            running_reg <= running_next;
            warn_reg    <= warn_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next state and digits: start > move_done > tick.
    always_comb begin
        state_next = state_reg;
        tens_next  = tens_reg;
        ones_next  = ones_reg;
        if (bus.start) begin
            state_next = RUN;
            tens_next  = LOAD_TENS;
            ones_next  = LOAD_ONES;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (bus.move_done) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        if (at_final) begin
                            state_next = EXPIRED;
                            tens_next  = '0;
                            ones_next  = '0;
                        end else if (ones_reg != 4'd0) begin
                            ones_next = ones_reg - 4'd1;
                        end else begin
                            ones_next = BCD_MAX;
                            tens_next = tens_reg - 4'd1;
                        end
                    end
                end
                IDLE, EXPIRED: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Flags are derived from the next state/digits so they change together with them.
    always_comb begin
        running_next = (state_next == RUN);
        warn_next    = running_next && (bcd_value(tens_next, ones_next) <= WARN_SECS);
        timeout_next = (state_reg == RUN) && (state_next == EXPIRED);
    end

    assign bus.tens    = tens_reg;
    assign bus.ones    = ones_reg;
    assign bus.running = running_reg;
    assign bus.warn    = warn_reg;
    assign bus.timeout = timeout_reg;

endmodule

// File: tb/tb_turn_timer.sv
// Self-checking bench for turn_timer: vector table, directed corner sequences and a
// randomized run against a seconds-level reference model.
module tb_turn_timer;

    localparam int CLK_HZ = 4;
    localparam int TURN   = 12;
    localparam int WARN   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    turn_timer_if bus ();

    turn_timer #(
        .CLK_HZ    (CLK_HZ),
        .TURN_SECS (TURN),
        .WARN_SECS (WARN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       s;
        logic       m;
        logic       p;
        logic [3:0] t;
        logic [3:0] o;
        logic       r;
        logic       w;
        logic       to;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining seconds as an integer, phase within the current second.
    int m_secs, m_phase, m_mode;   // m_mode: 0 idle, 1 running, 2 expired
    bit m_to;

    function automatic void add_vec(logic s, logic m, logic p, int t, int o, logic r, logic w, logic to);
        vec_t v;
        v.s = s; v.m = m; v.p = p;
        v.t = 4'(t); v.o = 4'(o);
        v.r = r; v.w = w; v.to = to;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int et, input int eo, input logic er,
                       input logic ew, input logic eto);
        logic [10:0] got, exp;
        got = {bus.tens, bus.ones, bus.running, bus.warn, bus.timeout};
        exp = {4'(et), 4'(eo), er, ew, eto};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got tens=%0d ones=%0d running=%0b warn=%0b timeout=%0b, expected tens=%0d ones=%0d running=%0b warn=%0b timeout=%0b",
                     name, bus.tens, bus.ones, bus.running, bus.warn, bus.timeout, et, eo, er, ew, eto);
        end
    endtask

    // Expected outputs from a seconds value straight from the output definitions.
    task automatic chk_secs(input string name, input int secs, input logic run, input logic to);
        chk(name, secs / 10, secs % 10, run, run && (secs <= WARN), to);
    endtask

    task automatic step(input logic s, input logic m, input logic p);
        bus.start = s;
        bus.move_done = m;
        bus.pause = p;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.move_done = 1'b0;
        bus.pause = 1'b0;
    endtask

    function automatic void model_step(bit s, bit md, bit p);
        m_to = 1'b0;
        if (s) begin
            m_secs = TURN; m_phase = 0; m_mode = 1;
        end else if (m_mode == 1 && md) begin
            m_mode = 0;
        end else if (m_mode == 1 && !p) begin
            m_phase++;
            if (m_phase == CLK_HZ) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = 2;
                    m_to = 1'b1;
                end
            end
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_secs = 0; m_phase = 0; m_mode = 0; m_to = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.move_done = 1'b0;
        bus.pause = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        //       s  m  p  t  o  r  w  to
        add_vec(0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 0, 0, 0);   // move_done in IDLE ignored
        add_vec(0, 0, 1, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 1, 2, 1, 0, 0);   // load 12
        add_vec(0, 0, 0, 1, 2, 1, 0, 0);
        add_vec(0, 0, 0, 1, 2, 1, 0, 0);
        add_vec(0, 0, 0, 1, 2, 1, 0, 0);
        add_vec(0, 0, 0, 1, 1, 1, 0, 0);   // first decrement CLK_HZ edges after start
        add_vec(0, 0, 1, 1, 1, 1, 0, 0);
        add_vec(0, 0, 1, 1, 1, 1, 0, 0);
        add_vec(0, 0, 0, 1, 1, 1, 0, 0);
        add_vec(1, 1, 0, 1, 2, 1, 0, 0);   // start beats move_done
        add_vec(0, 0, 0, 1, 2, 1, 0, 0);
        add_vec(0, 1, 0, 1, 2, 0, 0, 0);   // move_done stops, digits hold
        add_vec(0, 0, 0, 1, 2, 0, 0, 0);
        add_vec(0, 0, 0, 1, 2, 0, 0, 0);
        add_vec(1, 0, 1, 1, 2, 1, 0, 0);
        add_vec(0, 0, 1, 1, 2, 1, 0, 0);
        add_vec(0, 1, 1, 1, 2, 0, 0, 0);
        add_vec(0, 1, 0, 1, 2, 0, 0, 0);
        add_vec(1, 0, 0, 1, 2, 1, 0, 0);
        foreach (vq[i]) begin
            step(vq[i].s, vq[i].m, vq[i].p);
            $display("vec %0d: start=%0b move_done=%0b pause=%0b -> tens=%0d ones=%0d running=%0b",
                     i, vq[i].s, vq[i].m, vq[i].p, bus.tens, bus.ones, bus.running);
            chk($sformatf("vec%0d", i), int'(vq[i].t), int'(vq[i].o), vq[i].r, vq[i].w, vq[i].to);
        end

        // ---------------- full countdown, then EXPIRED hold and restart ----------------
        $display("seq countdown: start, %0d cycles to timeout", TURN * CLK_HZ);
        step(1, 0, 0);
        chk_secs("countdown_load", TURN, 1, 0);
        for (int c = 1; c <= TURN * CLK_HZ; c++) begin
            step(0, 0, 0);
            if (c == TURN * CLK_HZ) chk_secs("countdown_timeout", 0, 0, 1);
            else                    chk_secs($sformatf("countdown_c%0d", c), TURN - c / CLK_HZ, 1, 0);
        end
        for (int c = 0; c < 6; c++) begin
            step(0, 1, 0);
            chk_secs("expired_hold", 0, 0, 0);
        end
        $display("seq start in EXPIRED");
        step(1, 0, 0);
        chk_secs("expired_restart", TURN, 1, 0);

        // ---------------- pause preserving a partial second ----------------
        $display("seq pause at 0,9 with prescaler 2");
        step(1, 0, 0);
        for (int c = 1; c <= 14; c++) begin
            step(0, 0, 0);
            chk_secs("pause_approach", TURN - c / CLK_HZ, 1, 0);
        end
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 1);
            chk_secs("pause_frozen", 9, 1, 0);
        end
        step(0, 0, 0);
        chk_secs("pause_release1", 9, 1, 0);
        step(0, 0, 0);
        chk_secs("pause_release2", 8, 1, 0);

        // ---------------- move_done at 0,7 ----------------
        for (int c = 1; c <= CLK_HZ; c++) step(0, 0, 0);
        chk_secs("reach_07", 7, 1, 0);
        $display("seq move_done at 0,7");
        step(0, 1, 0);
        chk_secs("move_done_07", 7, 0, 0);
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 0);
            chk_secs("hold_07", 7, 0, 0);
        end
        step(1, 0, 0);
        chk_secs("reload_after_move", TURN, 1, 0);

        // ---------------- move_done coincident with final tick ----------------
        $display("seq move_done on final tick");
        for (int c = 1; c < TURN * CLK_HZ; c++) step(0, 0, 0);
        chk_secs("before_final", 1, 1, 0);
        step(0, 1, 0);
        chk_secs("move_done_final", 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0);
            chk_secs("hold_01", 1, 0, 0);
        end

        // ---------------- asynchronous reset mid-count ----------------
        $display("seq async reset mid-count");
        step(1, 0, 0);
        for (int c = 0; c < 6; c++) step(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_immediate", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("async_reset_held", 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 0);
            chk("after_reset_idle", 0, 0, 0, 0, 0);
        end

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            bit s, md, p;
            s  = ($urandom_range(0, 79) == 0);
            md = ($urandom_range(0, 59) == 0);
            p  = ($urandom_range(0, 4) == 0);
            step(s, md, p);
            model_step(s, md, p);
            if (s || md || m_to)
                $display("rand %0d: start=%0b move_done=%0b pause=%0b -> tens=%0d ones=%0d running=%0b timeout=%0b",
                         c, s, md, p, bus.tens, bus.ones, bus.running, bus.timeout);
            chk_secs($sformatf("rand_c%0d", c), m_secs, m_mode == 1, m_to);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
